inst_mem_loader: RTL
====================

Name: inst_mem_loader

Overview:
- Parametrised, run-time loadable instruction memory for the 16-bit CPU. It replaces a hard-coded program ROM.
- Holds up to DEPTH instruction words in inferred RAM. Serves one registered fetch port to the CPU.
- Accepts a new program as a framed byte stream: length byte, payload bytes, XOR checksum byte. The stream comes from a UART/host byte source.
- Holds the CPU in reset-equivalent NOP fetch while loading. Addresses at or beyond the loaded length fetch NOP.

Parameters:
- ADDR_W, 8, fetch/write address width.
- INST_W, 16, instruction width. Must be a multiple of 8. Bytes per word BPW = INST_W/8.
- DEPTH, 256, number of words. Must satisfy DEPTH <= 2**ADDR_W and DEPTH <= 256.

Ports:
- clk  in  1  system clock. All logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_addr  in  ADDR_W  CPU instruction address (PC).
- fetch_inst  out  INST_W  registered instruction. Valid one cycle after fetch_addr.
- load_start  in  1  request a new program load.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- cpu_hold  out  1  CPU must stall/hold PC. High while loading or in error.
- load_done  out  1  one-cycle pulse on successful load.
- load_err  out  1  sticky error flag (bad length or checksum).
- valid_words  out  ADDR_W+1  number of words of the current valid program.

Behaviour:
- Reset values:
  - State IDLE.
  - fetch_inst=0, byte_ready=0, cpu_hold=0, load_done=0, load_err=0, valid_words=0.
  - RAM contents are not cleared. They are masked by valid_words.
- Byte handshake: a byte is accepted on a rising edge where byte_valid && byte_ready. byte_ready=1 exactly in states LEN, DATA and CSUM.
- Fetch path, evaluated each cycle into the fetch_inst register:
  - If cpu_hold=1, or fetch_addr >= valid_words, or fetch_addr >= DEPTH, the register loads 0 (NOP).
  - Otherwise it loads mem[fetch_addr].
  - Latency is exactly 1 cycle.
- State machine:
  - IDLE: on load_start, go to LEN. Clear the checksum accumulator, word pointer wp=0, byte index bi=0 and load_err. cpu_hold=1 from the next cycle.
  - LEN: on an accepted byte L, set N=L+1 (word count 1..256).
    - If N > DEPTH: load_err=1, go to ERROR.
    - Otherwise latch N, XOR L into the checksum, go to DATA.
  - DATA: each accepted byte is XORed into the checksum and shifted into the word assembler, MSB-first.
    - When bi=BPW-1, write the assembled word to mem[wp] on that edge, then wp++, bi=0.
    - After word N-1 is written, go to CSUM.
  - CSUM: on an accepted byte C:
    - If C equals the accumulated checksum: valid_words=N, load_done=1 for the next cycle only, cpu_hold=0, go to IDLE.
    - Otherwise: load_err=1, valid_words=0, go to ERROR.
  - ERROR: cpu_hold=1 and load_err=1, held. load_start clears load_err and goes to LEN (same actions as from IDLE).
- valid_words=0 from entry to LEN until a successful CSUM. A failed load never leaves a partial program fetchable.
- load_start in LEN, DATA or CSUM is ignored. The load in progress continues.
- If load_start and byte_valid occur in IDLE in the same cycle, the byte is not accepted (byte_ready=0 in IDLE).
- rst mid-load: state returns to IDLE and valid_words=0. All fetches return NOP until the next successful load.
- The word pointer never exceeds N-1. There is no wrap-around in normal operation.

Decomposition:
- Shared CPU package holds: the opcode constants (NOP=0 … XOR=15), the NOP encoding, and the loader state encoding (IDLE, LEN, DATA, CSUM, ERROR).
- One sub-module is natural: inst_ram, a single-port inferred synchronous RAM with a registered read and a write port, parametrised by ADDR_W, INST_W and DEPTH.
- The FSM, word assembler, checksum and fetch masking stay in inst_mem_loader.

Test Plan:
1. After rst, fetch_addr=0..5 -> fetch_inst=16'h0000 every cycle, valid_words=0, byte_ready=0.
2. load_start, then bytes 8'h01, 8'h32, 8'h00, 8'h31, 8'h20, checksum 8'h22 -> load_done pulses 1 cycle after the checksum, cpu_hold falls, valid_words=2. fetch 0 -> 16'h3200 one cycle later, fetch 1 -> 16'h3120, fetch 2 -> 16'h0000.
3. Same stream with checksum 8'h23 -> load_err=1, cpu_hold stays 1, valid_words=0, fetch 0 -> 16'h0000. A new load_start plus a correct stream -> load_err clears and the program loads.
4. With DEPTH=4, length byte 8'h04 (N=5) -> load_err=1 right after the length byte, no RAM writes. Length 8'h03 loads 4 words and fetch 3 returns the last word.
5. byte_valid toggling 1/0 every cycle during DATA -> the identical final memory image as a continuous stream. load_start pulsed mid-DATA is ignored.
6. rst asserted after 3 payload bytes -> next cycle state IDLE, cpu_hold=0, valid_words=0, all fetches NOP. A subsequent full load succeeds.

Source files
------------

// File: rtl/inst_mem_loader_pkg.sv
// Shared CPU definitions: opcodes, NOP encoding and loader FSM state encoding.
// Imported by the instruction memory loader and its RAM.
package inst_mem_loader_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDI = 4'd1;
  localparam logic [3:0] OP_LD  = 4'd2;
  localparam logic [3:0] OP_ST  = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_JMP = 4'd8;
  localparam logic [3:0] OP_JZ  = 4'd9;
  localparam logic [3:0] OP_JNZ = 4'd10;
  localparam logic [3:0] OP_MOV = 4'd11;
  localparam logic [3:0] OP_SHL = 4'd12;
  localparam logic [3:0] OP_SHR = 4'd13;
  localparam logic [3:0] OP_NOT = 4'd14;
  localparam logic [3:0] OP_XOR = 4'd15;

  localparam logic [15:0] NOP_INST = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_ERROR
  } load_state_t;

endpackage

// File: rtl/inst_mem_loader_ram.sv
// Single-port synchronous instruction RAM with a registered read.
// Only the low index bits address the array; callers keep addr below DEPTH.
module inst_ram #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [INST_W-1:0] wdata,
  output logic [INST_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [INST_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              unused_addr_bits;

  assign idx              = addr[IDX_W-1:0];
  assign unused_addr_bits = ^addr;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Run-time loadable instruction memory: framed byte-stream loader (length,
// payload, XOR checksum) plus a masked, registered CPU fetch port.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int INST_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [INST_W-1:0] fetch_inst,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   valid_words
);

  localparam int            BPW     = INST_W / 8;
  localparam logic [7:0]    LAST_BI = 8'(BPW - 1);
  localparam logic [8:0]    DEPTH_N = 9'(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  load_state_t       state, state_n;
  logic [7:0]        csum, csum_n;
  logic [8:0]        wp, wp_n;
  logic [8:0]        n_words, n_words_n;
  logic [8:0]        len_words;
  logic [7:0]        bi, bi_n;
  logic [INST_W-1:0] asm_word, asm_n, asm_shift;
  logic [ADDR_W:0]   vw_n;
  logic              err_n, done_n;
  logic              accept, we;
  logic              fetch_ok, fetch_ok_q;
  logic [ADDR_W-1:0] ram_addr;
  logic [INST_W-1:0] ram_rdata;

  assign byte_ready = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
  assign cpu_hold   = (state != ST_IDLE);
  assign accept     = byte_valid && byte_ready;
  assign asm_shift  = (asm_word << 8) | INST_W'(byte_data);
  assign len_words  = {1'b0, byte_data} + 9'd1;

  always_comb begin
    state_n   = state;
    csum_n    = csum;
    wp_n      = wp;
    n_words_n = n_words;
    bi_n      = bi;
    asm_n     = asm_word;
    vw_n      = valid_words;
    err_n     = load_err;
    done_n    = 1'b0;
    we        = 1'b0;
    case (state)
      ST_IDLE, ST_ERROR: begin
        if (load_start) begin
          state_n = ST_LEN;
          csum_n  = 8'd0;
          wp_n    = 9'd0;
          bi_n    = 8'd0;
          err_n   = 1'b0;
          vw_n    = '0;
        end
      end
      ST_LEN: begin
        if (accept) begin
          if (len_words > DEPTH_N) begin
            err_n   = 1'b1;
            state_n = ST_ERROR;
          end else begin
            n_words_n = len_words;
            csum_n    = csum ^ byte_data;
            state_n   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          csum_n = csum ^ byte_data;
          asm_n  = asm_shift;
          // Completed word goes straight to RAM on this edge.
          if (bi == LAST_BI) begin
            we   = 1'b1;
            bi_n = 8'd0;
            wp_n = wp + 9'd1;
            if (wp == n_words - 9'd1) begin
              state_n = ST_CSUM;
            end
          end else begin
            bi_n = bi + 8'd1;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (byte_data == csum) begin
            vw_n    = (ADDR_W + 1)'(n_words);
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            err_n   = 1'b1;
            vw_n    = '0;
            state_n = ST_ERROR;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      csum        <= 8'd0;
      wp          <= 9'd0;
      n_words     <= 9'd0;
      bi          <= 8'd0;
      asm_word    <= '0;
      valid_words <= '0;
      load_err    <= 1'b0;
      load_done   <= 1'b0;
      fetch_ok_q  <= 1'b0;
    end else begin
      state       <= state_n;
      csum        <= csum_n;
      wp          <= wp_n;
      n_words     <= n_words_n;
      bi          <= bi_n;
      asm_word    <= asm_n;
      valid_words <= vw_n;
      load_err    <= err_n;
      load_done   <= done_n;
      fetch_ok_q  <= fetch_ok;
    end
  end

  // Writes only happen while the CPU is held, so sharing the port is safe.
  assign fetch_ok = !cpu_hold && ({1'b0, fetch_addr} < valid_words)
                    && ({1'b0, fetch_addr} < DEPTH_A);
  assign ram_addr = we ? ADDR_W'(wp) : fetch_addr;

  inst_ram #(
    .ADDR_W(ADDR_W),
    .INST_W(INST_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .addr (ram_addr),
    .wdata(asm_shift),
    .rdata(ram_rdata)
  );

  assign fetch_inst = fetch_ok_q ? ram_rdata : INST_W'(NOP_INST);

endmodule
